// File: rtl/writeback_buffer.sv
// writeback_buffer: in-order result FIFO feeding regfile and HI/LO.
// Ports: in_* lanes (valid/ready), rf_* write ports, hilo_*, fwd_*,
// wb_pc, busy. Define WB_FWD_EN to build the forwarding lookup.
module writeback_buffer #(
  parameter int LANES  = 2,
  parameter int WPORTS = 1,
  parameter int DEPTH  = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [LANES-1:0]    in_valid,
  output logic                in_ready,
  input  logic [LANES-1:0]    in_regwrite,
  input  logic [5*LANES-1:0]  in_writereg,
  input  logic [32*LANES-1:0] in_result,
  input  logic [LANES-1:0]    in_wen_h,
  input  logic [LANES-1:0]    in_wen_l,
  input  logic [32*LANES-1:0] in_hi,
  input  logic [32*LANES-1:0] in_lo,
  input  logic [32*LANES-1:0] in_pc,
  output logic [WPORTS-1:0]   rf_wen,
  output logic [5*WPORTS-1:0] rf_addr,
  output logic [32*WPORTS-1:0] rf_wd,
  output logic                hilo_wen_h,
  output logic                hilo_wen_l,
  output logic [31:0]         hilo_wd_h,
  output logic [31:0]         hilo_wd_l,
  input  logic [9:0]          fwd_addr,
  output logic [1:0]          fwd_hit,
  output logic [63:0]         fwd_data,
  output logic [31:0]         wb_pc,
  output logic                busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [CW-1:0] LIM = CW'(DEPTH - LANES);

  typedef struct packed {
    logic        regwrite;
    logic [4:0]  writereg;
    logic [31:0] result;
    logic        wen_h;
    logic        wen_l;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] pc;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;
  logic [CW-1:0]    n_push;
  logic [CW-1:0]    n_pop;
  entry_t           lane_e [LANES];
  logic [LANES-1:0] wr_en;
  logic [PW-1:0]    wr_idx [LANES];
  logic [31:0]      last_pc;

  function automatic logic [PW-1:0] wrap(
    input logic [PW-1:0] base,
    input int            off
  );
    return PW'((int'(base) + off) % DEPTH);
  endfunction

  assign in_ready = (count <= LIM);
  assign busy     = (count != '0);

  // Valid lanes are packed into consecutive slots from tail.
  always_comb begin
    n_push = '0;
    wr_en  = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_e[i] = '{
        regwrite: in_regwrite[i],
        writereg: in_writereg[i*5 +: 5],
        result:   in_result[i*32 +: 32],
        wen_h:    in_wen_h[i],
        wen_l:    in_wen_l[i],
        hi:       in_hi[i*32 +: 32],
        lo:       in_lo[i*32 +: 32],
        pc:       in_pc[i*32 +: 32]
      };
      wr_idx[i] = wrap(tail, int'(n_push));
      if (in_ready && in_valid[i]) begin
        wr_en[i] = 1'b1;
        n_push   = n_push + ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (wr_en[i]) begin
        mem[wr_idx[i]] <= lane_e[i];
      end
    end
  end

  // Drain oldest-first; HI/LO has a single port, so a second
  // HI/LO writer ends this cycle's drain (and all younger ones).
  always_comb begin
    entry_t e;
    logic   stop;
    logic   hl_used;
    e          = '0;
    stop       = 1'b0;
    hl_used    = 1'b0;
    n_pop      = '0;
    last_pc    = '0;
    rf_wen     = '0;
    rf_addr    = '0;
    rf_wd      = '0;
    hilo_wen_h = 1'b0;
    hilo_wen_l = 1'b0;
    hilo_wd_h  = '0;
    hilo_wd_l  = '0;
    for (int k = 0; k < WPORTS; k++) begin
      e = mem[wrap(head, k)];
      if (CW'(k) >= count) begin
        stop = 1'b1;
      end else if (hl_used && (e.wen_h || e.wen_l)) begin
        stop = 1'b1;
      end
      if (!stop) begin
        n_pop     = n_pop + ONE;
        last_pc   = e.pc;
        rf_wen[k] = e.regwrite && (e.writereg != 5'd0);
        rf_addr[k*5 +: 5]  = e.writereg;
        rf_wd[k*32 +: 32]  = e.result;
        if (e.wen_h || e.wen_l) begin
          hl_used    = 1'b1;
          hilo_wen_h = e.wen_h;
          hilo_wen_l = e.wen_l;
          hilo_wd_h  = e.wen_h ? e.hi : '0;
          hilo_wd_l  = e.wen_l ? e.lo : '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      wb_pc <= 32'hBFC0_0000;
    end else begin
      head  <= wrap(head, int'(n_pop));
      tail  <= wrap(tail, int'(n_push));
      count <= count + n_push - n_pop;
      if (n_pop != '0) begin
        wb_pc <= last_pc;
      end
    end
  end

`ifdef WB_FWD_EN
  // Scan oldest to youngest so the youngest match wins.
  always_comb begin
    entry_t     f;
    logic [4:0] a;
    f        = '0;
    a        = '0;
    fwd_hit  = '0;
    fwd_data = '0;
    for (int q = 0; q < 2; q++) begin
      a = fwd_addr[q*5 +: 5];
      for (int i = 0; i < DEPTH; i++) begin
        f = mem[wrap(head, i)];
        if (CW'(i) < count && f.regwrite &&
            f.writereg == a && a != 5'd0) begin
          fwd_hit[q]            = 1'b1;
          fwd_data[q*32 +: 32]  = f.result;
        end
      end
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^fwd_addr;
  assign fwd_hit    = '0;
  assign fwd_data   = '0;
`endif

endmodule

// File: tb/tb_writeback_buffer.sv
// tb_writeback_buffer: random + directed bench, queue reference model.
// Two DUTs share stimulus: WPORTS=1 (a) and WPORTS=2 (b).
module tb_writeback_buffer;

  localparam int LANES = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic [LANES-1:0]    in_valid;
  logic [LANES-1:0]    in_regwrite;
  logic [5*LANES-1:0]  in_writereg;
  logic [32*LANES-1:0] in_result;
  logic [LANES-1:0]    in_wen_h;
  logic [LANES-1:0]    in_wen_l;
  logic [32*LANES-1:0] in_hi;
  logic [32*LANES-1:0] in_lo;
  logic [32*LANES-1:0] in_pc;
  logic [9:0]          fwd_addr;

  logic        a_ready, a_hwh, a_hwl, a_busy;
  logic [0:0]  a_wen;
  logic [4:0]  a_addr;
  logic [31:0] a_wd, a_hdh, a_hdl, a_pc;
  logic [1:0]  a_fhit;
  logic [63:0] a_fdata;

  logic        b_ready, b_hwh, b_hwl, b_busy;
  logic [1:0]  b_wen;
  logic [9:0]  b_addr;
  logic [63:0] b_wd;
  logic [31:0] b_hdh, b_hdl, b_pc;
  logic [1:0]  b_fhit;
  logic [63:0] b_fdata;

  writeback_buffer #(
    .LANES(LANES), .WPORTS(1), .DEPTH(DEPTH)
  ) u_a (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(a_ready),
    .in_regwrite(in_regwrite), .in_writereg(in_writereg),
    .in_result(in_result),
    .in_wen_h(in_wen_h), .in_wen_l(in_wen_l),
    .in_hi(in_hi), .in_lo(in_lo), .in_pc(in_pc),
    .rf_wen(a_wen), .rf_addr(a_addr), .rf_wd(a_wd),
    .hilo_wen_h(a_hwh), .hilo_wen_l(a_hwl),
    .hilo_wd_h(a_hdh), .hilo_wd_l(a_hdl),
    .fwd_addr(fwd_addr), .fwd_hit(a_fhit),
    .fwd_data(a_fdata), .wb_pc(a_pc), .busy(a_busy)
  );

  writeback_buffer #(
    .LANES(LANES), .WPORTS(2), .DEPTH(DEPTH)
  ) u_b (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(b_ready),
    .in_regwrite(in_regwrite), .in_writereg(in_writereg),
    .in_result(in_result),
    .in_wen_h(in_wen_h), .in_wen_l(in_wen_l),
    .in_hi(in_hi), .in_lo(in_lo), .in_pc(in_pc),
    .rf_wen(b_wen), .rf_addr(b_addr), .rf_wd(b_wd),
    .hilo_wen_h(b_hwh), .hilo_wen_l(b_hwl),
    .hilo_wd_h(b_hdh), .hilo_wd_l(b_hdl),
    .fwd_addr(fwd_addr), .fwd_hit(b_fhit),
    .fwd_data(b_fdata), .wb_pc(b_pc), .busy(b_busy)
  );

  typedef struct packed {
    logic        rw;
    logic [4:0]  wr;
    logic [31:0] res;
    logic        wh;
    logic        wl;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] pc;
  } ent_t;

  ent_t        qa[$];
  ent_t        qb[$];
  logic [31:0] pca;
  logic [31:0] pcb;
  int          total;
  int          bad;
  logic [31:0] pcn;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    in_valid    = '0;
    in_regwrite = '0;
    in_writereg = '0;
    in_result   = '0;
    in_wen_h    = '0;
    in_wen_l    = '0;
    in_hi       = '0;
    in_lo       = '0;
    in_pc       = '0;
  endtask

  task automatic put(
    input int          l,
    input logic        rw,
    input logic [4:0]  r,
    input logic [31:0] d,
    input logic        wh,
    input logic [31:0] h
  );
    in_valid[l]          = 1'b1;
    in_regwrite[l]       = rw;
    in_writereg[l*5+:5]  = r;
    in_result[l*32+:32]  = d;
    in_wen_h[l]          = wh;
    in_hi[l*32+:32]      = h;
    in_wen_l[l]          = 1'b0;
    in_lo[l*32+:32]      = '0;
    in_pc[l*32+:32]      = pcn;
    pcn                  = pcn + 32'd4;
  endtask

  task automatic rand_in();
    idle();
    for (int l = 0; l < LANES; l++) begin
      in_valid[l]          = ($urandom_range(0, 3) != 0);
      in_regwrite[l]       = $urandom_range(0, 1) == 1;
      in_writereg[l*5+:5]  = 5'($urandom_range(0, 7));
      in_result[l*32+:32]  = $urandom;
      in_wen_h[l]          = ($urandom_range(0, 3) == 0);
      in_wen_l[l]          = ($urandom_range(0, 3) == 0);
      in_hi[l*32+:32]      = $urandom;
      in_lo[l*32+:32]      = $urandom;
      in_pc[l*32+:32]      = $urandom;
    end
    fwd_addr = {5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7))};
  endtask

  // Expected behaviour of one buffer this cycle, then advance it.
  task automatic model(input int d);
    ent_t        q[$];
    ent_t        e;
    int          w, n;
    logic        hl, done, rdy;
    logic [31:0] pc;
    logic [1:0]  xwen, gwen, xhit, ghit;
    logic [9:0]  xad, gad;
    logic [63:0] xwd, gwd, xfd, gfd;
    logic        xhh, xhl, ghh, ghl, grdy, gbusy;
    logic [31:0] xdh, xdl, gdh, gdl, gpc;
    logic [4:0]  fa;
    string       p;
    if (d == 0) begin
      q = qa; pc = pca; w = 1; p = "a";
      gwen = {1'b0, a_wen}; gad = {5'd0, a_addr};
      gwd = {32'd0, a_wd}; ghh = a_hwh; ghl = a_hwl;
      gdh = a_hdh; gdl = a_hdl; grdy = a_ready;
      gbusy = a_busy; gpc = a_pc; ghit = a_fhit;
      gfd = a_fdata;
    end else begin
      q = qb; pc = pcb; w = 2; p = "b";
      gwen = b_wen; gad = b_addr; gwd = b_wd;
      ghh = b_hwh; ghl = b_hwl; gdh = b_hdh;
      gdl = b_hdl; grdy = b_ready; gbusy = b_busy;
      gpc = b_pc; ghit = b_fhit; gfd = b_fdata;
    end
    rdy = (q.size() <= DEPTH - LANES);
    xwen = '0; xad = '0; xwd = '0;
    xhh = 1'b0; xhl = 1'b0; xdh = '0; xdl = '0;
    n = 0; hl = 1'b0; done = 1'b0;
    for (int k = 0; k < w; k++) begin
      if (!done && k < q.size()) begin
        e = q[k];
        if ((e.wh || e.wl) && hl) begin
          done = 1'b1;
        end else begin
          if (e.wh || e.wl) begin
            hl = 1'b1;
            xhh = e.wh; xhl = e.wl;
            xdh = e.wh ? e.hi : '0;
            xdl = e.wl ? e.lo : '0;
          end
          if (e.rw && e.wr != 5'd0) begin
            xwen[k] = 1'b1;
            xad[k*5+:5] = e.wr;
            xwd[k*32+:32] = e.res;
          end
          n++;
        end
      end else begin
        done = 1'b1;
      end
    end
    xhit = '0; xfd = '0;
`ifdef WB_FWD_EN
    for (int f = 0; f < 2; f++) begin
      fa = fwd_addr[f*5+:5];
      foreach (q[i]) begin
        if (q[i].rw && q[i].wr == fa && fa != 5'd0) begin
          xhit[f] = 1'b1;
          xfd[f*32+:32] = q[i].res;
        end
      end
    end
`else
    fa = '0;
`endif
    chk({p, ".ready"}, grdy, rdy);
    chk({p, ".busy"}, gbusy, q.size() != 0);
    chk({p, ".wb_pc"}, gpc, pc);
    for (int k = 0; k < w; k++) begin
      chk({p, ".rf_wen"}, gwen[k], xwen[k]);
      if (xwen[k] || k >= n) begin
        chk({p, ".rf_addr"}, gad[k*5+:5], xad[k*5+:5]);
        chk({p, ".rf_wd"}, gwd[k*32+:32], xwd[k*32+:32]);
      end
    end
    chk({p, ".hilo_wen"}, {ghh, ghl}, {xhh, xhl});
    chk({p, ".hilo_wd"}, {gdh, gdl}, {xdh, xdl});
    chk({p, ".fwd_hit"}, ghit, xhit);
    chk({p, ".fwd_data"}, gfd, xfd);
    if (n > 0) pc = q[n-1].pc;
    for (int k = 0; k < n; k++) void'(q.pop_front());
    if (rdy) begin
      for (int l = 0; l < LANES; l++) begin
        if (in_valid[l]) begin
          e = '{rw: in_regwrite[l], wr: in_writereg[l*5+:5],
                res: in_result[l*32+:32], wh: in_wen_h[l],
                wl: in_wen_l[l], hi: in_hi[l*32+:32],
                lo: in_lo[l*32+:32], pc: in_pc[l*32+:32]};
          q.push_back(e);
        end
      end
    end
    if (d == 0) begin qa = q; pca = pc; end
    else begin qb = q; pcb = pc; end
  endtask

  task automatic step();
    @(negedge clk);
    model(0);
    model(1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < 12; i++) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0; pcn = 32'h0000_1000;
    pca = 32'hBFC0_0000; pcb = 32'hBFC0_0000;
    idle();
    fwd_addr = '0;
    resetn = 1'b1;
    #1 resetn = 1'b0;
    #1;
    chk("rst.busy", {a_busy, b_busy}, 2'b00);
    chk("rst.pc", a_pc, 32'hBFC0_0000);
    chk("rst.wen", {a_wen, b_wen}, 3'b000);
    chk("rst.ready", {a_ready, b_ready}, 2'b11);
    #10 resetn = 1'b1;
    @(posedge clk); #1;

    // two lanes, one write port: $3 then $4
    put(0, 1'b1, 5'd3, 32'h11, 1'b0, 32'h0);
    put(1, 1'b1, 5'd4, 32'h22, 1'b0, 32'h0);
    step();
    idle();
    chk("seq.wen1", a_wen, 1'b1);
    chk("seq.addr1", a_addr, 5'd3);
    chk("seq.wd1", a_wd, 32'h11);
    step();
    chk("seq.addr2", a_addr, 5'd4);
    chk("seq.wd2", a_wd, 32'h22);
    chk("seq.busy2", a_busy, 1'b1);
    step();
    chk("seq.busy3", a_busy, 1'b0);
    drain();

    // fill to 3, hold lanes until accepted
    put(0, 1'b1, 5'd6, 32'hA0, 1'b0, 32'h0);
    put(1, 1'b1, 5'd7, 32'hA1, 1'b0, 32'h0);
    step();
    put(0, 1'b1, 5'd8, 32'hA2, 1'b0, 32'h0);
    put(1, 1'b1, 5'd9, 32'hA3, 1'b0, 32'h0);
    step();
    put(0, 1'b1, 5'd10, 32'hA4, 1'b0, 32'h0);
    put(1, 1'b1, 5'd11, 32'hA5, 1'b0, 32'h0);
    chk("full.ready", a_ready, 1'b0);
    begin
      int t;
      for (t = 0; t < 8 && qa.size() > DEPTH - LANES; t++)
        step();
      chk("hold.timeout", t < 8, 1'b1);
    end
    step();
    drain();

    // two adjacent MULT results, two write ports
    put(0, 1'b0, 5'd0, 32'h0, 1'b1, 32'h1);
    put(1, 1'b0, 5'd0, 32'h0, 1'b1, 32'h2);
    step();
    idle();
    chk("mult.wen1", b_hwh, 1'b1);
    chk("mult.hi1", b_hdh, 32'h1);
    step();
    chk("mult.wen2", b_hwh, 1'b1);
    chk("mult.hi2", b_hdh, 32'h2);
    drain();

    // write to $0 pops silently
    put(0, 1'b1, 5'd0, 32'hFF, 1'b0, 32'h0);
    step();
    idle();
    chk("zero.wen", a_wen, 1'b0);
    chk("zero.busy", a_busy, 1'b1);
    step();
    chk("zero.pop", a_busy, 1'b0);
    drain();

    // forwarding: youngest of two $5 writers
    fwd_addr = {5'd7, 5'd5};
    put(0, 1'b1, 5'd5, 32'hA, 1'b0, 32'h0);
    put(1, 1'b1, 5'd5, 32'hB, 1'b0, 32'h0);
    step();
    idle();
`ifdef WB_FWD_EN
    chk("fwd.hit", a_fhit, 2'b01);
    chk("fwd.data", a_fdata[31:0], 32'hB);
`else
    chk("fwd.hit", a_fhit, 2'b00);
    chk("fwd.data", a_fdata[31:0], 32'h0);
`endif
    drain();

    // reset in the middle of a drain
    fwd_addr = {5'd0, 5'd6};
    put(0, 1'b1, 5'd6, 32'hC0, 1'b1, 32'h5);
    put(1, 1'b1, 5'd6, 32'hC1, 1'b0, 32'h0);
    step();
    put(0, 1'b1, 5'd6, 32'hC2, 1'b0, 32'h0);
    put(1, 1'b1, 5'd6, 32'hC3, 1'b0, 32'h0);
    step();
    idle();
    #1 resetn = 1'b0;
    #1;
    chk("mrst.wen", {a_wen, b_wen}, 3'b000);
    chk("mrst.busy", {a_busy, b_busy}, 2'b00);
    chk("mrst.pc", {a_pc, b_pc}, {2{32'hBFC0_0000}});
    chk("mrst.hilo", {a_hwh, a_hwl, b_hwh, b_hwl}, 4'h0);
    chk("mrst.fwd", {a_fhit, b_fhit}, 4'h0);
    chk("mrst.ready", a_ready, 1'b1);
    qa.delete(); qb.delete();
    pca = 32'hBFC0_0000; pcb = 32'hBFC0_0000;
    #1 resetn = 1'b1;
    put(0, 1'b1, 5'd9, 32'h99, 1'b0, 32'h0);
    step();
    idle();
    chk("mrst.addr", a_addr, 5'd9);
    chk("mrst.wd", a_wd, 32'h99);
    drain();

    // random traffic
    for (int c = 0; c < 400; c++) begin
      rand_in();
      step();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/writeback_buffer.md
WRITEBACK_BUFFER -- requirements
Module: writeback_buffer

Interface
REQ-001 SHALL have parameter LANES, default 2: issue lanes presented per cycle (1..4).
REQ-002 SHALL have parameter WPORTS, default 1: regfile write ports (1..LANES).
REQ-003 SHALL have parameter DEPTH, default 4: buffer entries, power of 2, >= LANES.
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port resetn, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, LANES: per-lane result present; lane 0 is oldest.
REQ-007 SHALL have port in_ready, output, 1: the buffer accepts this cycle's lanes.
REQ-008 SHALL have port in_regwrite, input, LANES: per-lane GPR write request.
REQ-009 SHALL have port in_writereg, input, 5*LANES: per-lane destination GPR.
REQ-010 SHALL have port in_result, input, 32*LANES: per-lane result (memory read data or ALU output, already selected).
REQ-011 SHALL have port in_wen_h / in_wen_l, input, LANES each: per-lane HI/LO write enables.
REQ-012 SHALL have port in_hi / in_lo, input, 32*LANES each: per-lane HI/LO write data.
REQ-013 SHALL have port in_pc, input, 32*LANES: per-lane instruction PC.
REQ-014 SHALL have port rf_wen, output, WPORTS: regfile write enables; port 0 is oldest.
REQ-015 SHALL have port rf_addr / rf_wd, output, 5*WPORTS / 32*WPORTS: regfile write address and data.
REQ-016 SHALL have port hilo_wen_h / hilo_wen_l, output, 1 each: HI/LO write enables.
REQ-017 SHALL have port hilo_wd_h / hilo_wd_l, output, 32 each: HI/LO write data.
REQ-018 SHALL have port fwd_addr, input, 10: two forwarding query addresses (rs, rt).
REQ-019 SHALL have port fwd_hit / fwd_data, output, 2 / 64: forwarding hit flags and data.
REQ-020 SHALL have port wb_pc, output, 32: registered PC of the youngest entry retired so far.
REQ-021 SHALL have port busy, output, 1: high when count != 0.

Function
REQ-022 SHALL hold entries in a circular FIFO with head and tail pointers that wrap modulo DEPTH, and a count of width clog2(DEPTH+1).
REQ-023 SHALL drive in_ready = (count <= DEPTH-LANES), using the count at cycle start and ignoring same-cycle drain.
REQ-024 SHALL, when in_ready is high and any in_valid bit is set, enqueue only the valid lanes, compacted in lane order; invalid lanes consume no entry.
REQ-025 SHALL ignore all inputs while in_ready is low; the upstream stage holds them.
REQ-026 SHALL present head entries combinationally; an entry enqueued at edge N drives its write in cycle N+1 and is popped at edge N+1.
REQ-027 SHALL pop up to WPORTS oldest entries per cycle, in order, and assign the k-th popped entry to rf port k.
REQ-028 SHALL set rf_wen[k] = regwrite && writereg != 0 for each popped entry; entries with a zero enable still pop.
REQ-029 SHALL drive HI/LO from at most one popped entry per cycle; the drain stops before a second entry with wen_h or wen_l in the same cycle.
REQ-030 SHALL, on simultaneous enqueue and pop, update count = count + pushed - popped; the count never exceeds DEPTH and never underflows.
REQ-031 SHALL drive unused rf ports and idle HI/LO outputs with enable 0 and data 0.
REQ-032 SHALL set fwd_hit[q] when any buffered entry, including one popping this cycle, has regwrite, writereg == fwd_addr[q] and fwd_addr[q] != 0; fwd_data[q] is the youngest such result.

Reset
REQ-033 SHALL, when resetn is low, asynchronously clear head, tail and count, set wb_pc = 0xBFC00000 and busy = 0, and force rf_wen, hilo_wen_h, hilo_wen_l and fwd_hit to 0; entries in flight mid-drain are discarded.
REQ-034 SHALL leave the entry data storage without reset.

Configuration
REQ-035 SHALL compile the forwarding lookup only when WB_FWD_EN is defined; without it, fwd_hit = 0 and fwd_data = 0, and fwd_addr is ignored.

Verification
REQ-036 SHALL test: LANES=2, WPORTS=1: both lanes valid, regwrite=1 to $3 and $4 with 0x11 and 0x22 -> cycle+1 writes $3=0x11, cycle+2 writes $4=0x22, busy falls after cycle+2.
REQ-037 SHALL test: DEPTH=4 filled to count=3 -> in_ready=0, and lanes held two cycles are accepted once count<=2 with no loss or duplication.
REQ-038 SHALL test: WPORTS=2 with two adjacent MULT entries (hi 0x1/0x2) -> one HI write per cycle, 0x1 then 0x2.
REQ-039 SHALL test: writes to $0 with 0xFF -> rf_wen=0 and the entry still pops.
REQ-040 SHALL test: with WB_FWD_EN, two pending writes to $5 (0xA older, 0xB younger) and fwd_addr=$5 -> hit=1, data=0xB; without the macro -> hit=0.
REQ-041 SHALL test: resetn low mid-drain with count=3 -> outputs as in REQ-033 immediately, and the first write after release comes from a new enqueue.
